vend_input_cond: RTL and testbench

//  Input conditioner ahead of the vending FSM. Synchronises and debounces the five raw

---
 rtl/vend_input_cond_if.sv | 24 ++
 rtl/vend_input_cond.sv | 101 ++++++++++
 tb/tb_vend_input_cond.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/vend_input_cond_if.sv
// rtl/vend_input_cond_if.sv - front-panel button inputs and conditioned command outputs
// Slave side is the conditioner; master side drives the raw buttons and observes commands.
interface vend_input_cond_if;
   logic       btn_coin1;
   logic       btn_coin10;
   logic       btn_drink1;
   logic       btn_drink2;
   logic       btn_cancel;
   logic       insert;
   logic [1:0] coin_val;
   logic [1:0] drink_op;
   logic       cancel_flag;
   logic       busy;

   modport slave (
      input  btn_coin1, btn_coin10, btn_drink1, btn_drink2, btn_cancel,
      output insert, coin_val, drink_op, cancel_flag, busy
   );

   modport master (
      output btn_coin1, btn_coin10, btn_drink1, btn_drink2, btn_cancel,
      input  insert, coin_val, drink_op, cancel_flag, busy
   );
endinterface

// File: rtl/vend_input_cond.sv
// rtl/vend_input_cond.sv - button synchroniser, debouncer and priority command serialiser
// Each debounced rise becomes one pending event; events drain one per MIN_GAP+1 cycles.
module vend_input_cond #(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int MIN_GAP         = 2
) (
   input logic            clk,
   input logic            rst_n,
   vend_input_cond_if.slave bus
);
   localparam int NB = 5;
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

   // Bit order doubles as priority: higher index wins.
   logic [NB-1:0] raw;
   assign raw = {bus.btn_cancel, bus.btn_coin10, bus.btn_coin1, bus.btn_drink2, bus.btn_drink1};

   logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NB-1:0] stable_q, stable_d, stable_prev_q, stable_prev_d;
   logic [NB-1:0] pend_q, pend_d, grant;
   logic [CW-1:0] cnt_q [NB];
   logic [CW-1:0] cnt_d [NB];
   logic [GW-1:0] gap_q, gap_d;
   logic          insert_q, insert_d, cancel_q, cancel_d;
   logic [1:0]    coin_val_q, coin_val_d, drink_op_q, drink_op_d;

   always_comb begin
      sync1_d       = raw;
      sync2_d       = sync1_q;
      stable_d      = stable_q;
      stable_prev_d = stable_q;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1))
               stable_d[i] = sync2_q[i];
            else
               cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (gap_q == '0) begin
         for (int i = 0; i < NB; i++) begin
            if (pend_q[i]) begin
               grant    = '0;
               grant[i] = 1'b1;
            end
         end
      end
      // A rise landing on the same edge its flag is granted still re-arms the flag.
      pend_d = (pend_q & ~grant) | (stable_q & ~stable_prev_q);
      if (|grant)
         gap_d = GW'(MIN_GAP);
      else if (gap_q != '0)
         gap_d = gap_q - GW'(1);
      else
         gap_d = gap_q;
      cancel_d   = grant[4];
      insert_d   = grant[3] | grant[2];
      coin_val_d = grant[3] ? 2'b10 : (grant[2] ? 2'b01 : 2'b00);
      drink_op_d = grant[1] ? 2'd2  : (grant[0] ? 2'd1  : 2'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         pend_q        <= '0;
         gap_q         <= '0;
         insert_q      <= 1'b0;
         cancel_q      <= 1'b0;
         coin_val_q    <= 2'b00;
         drink_op_q    <= 2'd0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         pend_q        <= pend_d;
         gap_q         <= gap_d;
         insert_q      <= insert_d;
         cancel_q      <= cancel_d;
         coin_val_q    <= coin_val_d;
         drink_op_q    <= drink_op_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign bus.insert      = insert_q;
   assign bus.coin_val    = coin_val_q;
   assign bus.drink_op    = drink_op_q;
   assign bus.cancel_flag = cancel_q;
   assign bus.busy        = (|pend_q) | (gap_q != '0);
endmodule

// File: tb/tb_vend_input_cond.sv
// tb/tb_vend_input_cond.sv - scoreboard bench for vend_input_cond (DEBOUNCE_CYCLES=4, MIN_GAP=2)
// Kinds: 1 coin1, 2 coin10, 3 drink1, 4 drink2, 5 cancel.
module tb_vend_input_cond;
   logic clk = 1'b0;
   logic rst_n;
   vend_input_cond_if bus ();

   vend_input_cond #(.DEBOUNCE_CYCLES(4), .MIN_GAP(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t;
      int kind;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   bit   mon_en = 1'b0;
   int   mk, mn;
   exp_t me;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mn = 0;
         mk = 0;
         if (bus.cancel_flag) begin mn++; mk = 5; end
         if (bus.insert) begin
            mn++;
            mk = (bus.coin_val == 2'b10) ? 2 : ((bus.coin_val == 2'b01) ? 1 : 9);
         end
         if (bus.drink_op != 2'd0) begin
            mn++;
            mk = (bus.drink_op == 2'd2) ? 4 : ((bus.drink_op == 2'd1) ? 3 : 9);
         end
         chk(mn <= 1, "exclusive", mn, 1);
         if (!bus.insert) chk(bus.coin_val == 2'b00, "coin_val_idle", int'(bus.coin_val), 0);
         if (mn > 0) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_pulse", mk, 0);
            end else begin
               me = exp_q.pop_front();
               chk(mk == me.kind, "pulse_kind", mk, me.kind);
               chk(edge_cnt == me.t, "pulse_time", edge_cnt, me.t);
            end
         end
      end
   end

   task automatic all_btn(input logic v);
      bus.btn_coin1  = v;
      bus.btn_coin10 = v;
      bus.btn_drink1 = v;
      bus.btn_drink2 = v;
      bus.btn_cancel = v;
   endtask

   task automatic quiet_check(input string name);
      chk(exp_q.size() == 0, {name, "_drained"}, exp_q.size(), 0);
      chk(bus.busy == 1'b0, {name, "_busy"}, int'(bus.busy), 0);
   endtask

   int t0;

   initial begin
      all_btn(1'b0);
      rst_n = 1'b0;
      step(3);
      chk(bus.insert == 1'b0, "rst_insert", int'(bus.insert), 0);
      chk(bus.coin_val == 2'b00, "rst_coin_val", int'(bus.coin_val), 0);
      chk(bus.drink_op == 2'd0, "rst_drink_op", int'(bus.drink_op), 0);
      chk(bus.cancel_flag == 1'b0, "rst_cancel", int'(bus.cancel_flag), 0);
      chk(bus.busy == 1'b0, "rst_busy", int'(bus.busy), 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step(2);

      // 1: coin10 held 20 cycles
      t0 = edge_cnt + 1;
      exp_q.push_back('{t0 + 7, 2});
      bus.btn_coin10 = 1'b1;
      step(20);
      bus.btn_coin10 = 1'b0;
      step(30);
      quiet_check("t1");

      // 2: drink1 glitch of 3 cycles
      bus.btn_drink1 = 1'b1;
      step(3);
      bus.btn_drink1 = 1'b0;
      step(30);
      quiet_check("t2");

      // 3: all five together drain by priority
      t0 = edge_cnt + 1;
      exp_q.push_back('{t0 + 7, 5});
      exp_q.push_back('{t0 + 10, 2});
      exp_q.push_back('{t0 + 13, 1});
      exp_q.push_back('{t0 + 16, 4});
      exp_q.push_back('{t0 + 19, 3});
      all_btn(1'b1);
      step(25);
      all_btn(1'b0);
      step(30);
      quiet_check("t3");

      // 4: coin1 bounce then hold
      for (int i = 0; i < 10; i++) begin
         bus.btn_coin1 = (i % 2 == 0);
         step(1);
      end
      t0 = edge_cnt + 1;
      exp_q.push_back('{t0 + 7, 1});
      bus.btn_coin1 = 1'b1;
      step(20);
      bus.btn_coin1 = 1'b0;
      step(30);
      quiet_check("t4");

      // 5: reset while cancel is pending, button held through reset
      t0 = edge_cnt + 1;
      bus.btn_cancel = 1'b1;
      step(7);
      rst_n = 1'b0;
      step(2);
      chk(bus.busy == 1'b0, "t5_rst_busy", int'(bus.busy), 0);
      rst_n = 1'b1;
      t0 = edge_cnt + 1;
      exp_q.push_back('{t0 + 7, 5});
      step(20);
      bus.btn_cancel = 1'b0;
      step(30);
      quiet_check("t5");

      // 6: three separate coin1 presses
      for (int r = 0; r < 3; r++) begin
         t0 = edge_cnt + 1;
         exp_q.push_back('{t0 + 7, 1});
         bus.btn_coin1 = 1'b1;
         step(8);
         bus.btn_coin1 = 1'b0;
         step(8);
      end
      step(30);
      quiet_check("t6");

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
